qeciphy_rx_crc8_checker: RTL and testbench
==========================================

// Module: qeciphy_rx_crc8_checker
//
// PURPOSE
// - Receive-side CRC-8/SMBUS checker for the PHY byte stream.
// - Frame format: FRAME_BYTES payload bytes, then 1 CRC byte on the last beat (tlast).
// - Keeps a running CRC over the payload and compares it with the received CRC byte.
// - Forwards the payload with a fixed latency, flags good and bad frames, and asserts
//   a sticky link-fail after repeated bad frames.
//
// PARAMETERS
// - FRAME_BYTES  8   payload bytes per frame, excluding CRC; legal range 1..255
// - FAIL_THRESH  4   consecutive bad frames that set link_fail_o; legal range >= 1
// - CNT_W        16  width of the error counter (only when the optional feature is built)
//
// PORTS
// - clk_i         in   1      single clock for all logic
// - rst_n_i       in   1      reset, asynchronous, active-low
// - rx_data_i     in   8      received byte
// - rx_valid_i    in   1      rx_data_i is valid; no backpressure, so every valid beat is consumed
// - rx_last_i     in   1      marks the CRC byte, i.e. the final beat of a frame
// - clear_i       in   1      clears link_fail_o and the consecutive-error count
// - data_o        out  8      forwarded payload byte; CRC byte is never forwarded
// - valid_o       out  1      data_o is valid
// - frame_ok_o    out  1      1-cycle pulse: frame passed
// - frame_err_o   out  1      1-cycle pulse: CRC mismatch or framing error
// - frame_fmt_o   out  1      qualifies frame_err_o: 1 = framing error, 0 = CRC mismatch
// - link_fail_o   out  1      sticky: FAIL_THRESH consecutive bad frames seen
// - err_cnt_o     out  CNT_W  saturating bad-frame count (optional feature only)
//
// BEHAVIOUR
// Reset
// - All outputs reset to 0.
// - Running CRC and byte counter reset to 0 (CRC init 0x00); FSM resets to ST_PAYLOAD.
//
// CRC definition
// - Polynomial 0x07, init 0x00, MSB-first, no reflection, xorout 0x00.
// - Update per byte: crc <= crc8_step(crc, byte).
//
// Latency
// - data_o/valid_o are registered and lag the input by 1 cycle.
// - frame_ok_o / frame_err_o / frame_fmt_o pulse 1 cycle after the CRC beat.
//
// FSM
// - ST_PAYLOAD (valid beat)
//   - rx_last_i=0: forward the byte, update the CRC, increment the counter.
//   - When the counter reaches FRAME_BYTES, go to ST_CHECK.
//   - rx_last_i=1 here is an early tlast: pulse frame_err_o with frame_fmt_o=1, do not
//     forward the byte, reset CRC and counter, stay in ST_PAYLOAD.
// - ST_CHECK (valid beat)
//   - rx_last_i=1: compare rx_data_i with the CRC. Match pulses frame_ok_o; mismatch pulses
//     frame_err_o with frame_fmt_o=0. Reset CRC and counter, go to ST_PAYLOAD.
//   - rx_last_i=0: missing tlast. Pulse frame_err_o with frame_fmt_o=1, go to ST_SYNC.
// - ST_SYNC
//   - Discard valid beats and forward nothing.
//   - A beat with rx_last_i=1 resets CRC and counter and returns to ST_PAYLOAD.
//   - No further status pulses are issued while in ST_SYNC.
//
// Idle beats
// - Beats with rx_valid_i=0 change nothing. Gaps inside a frame are legal.
//
// Consecutive-error logic
// - Every frame_err_o increments the consecutive count, saturating at FAIL_THRESH.
// - frame_ok_o clears the consecutive count but does not clear link_fail_o.
// - link_fail_o sets in the same cycle the count reaches FAIL_THRESH.
// - link_fail_o stays set until clear_i or reset.
// - clear_i in the same cycle as a frame_err_o: clear wins, and the count restarts at 0.
//
// Reset mid-frame
// - The partial frame is dropped silently. The block restarts in ST_PAYLOAD.
//
// CONFIGURATION
// - Macro QECIPHY_RX_CRC_ERR_CNT_EN
//   - Defined: err_cnt_o is a CNT_W saturating counter of frame_err_o pulses.
//     It holds at all-ones and is cleared only by reset, not by clear_i.
//   - Undefined: the counter logic is not built and err_cnt_o is tied to 0.
//
// STRUCTURE
// - Package qeciphy_crc_pkg holds:
//   - CRC8_POLY = 8'h07 and CRC8_INIT = 8'h00
//   - function crc8_step(crc, byte), shared with the TX CRC insert path
//   - typedef enum {ST_PAYLOAD, ST_CHECK, ST_SYNC} rx_crc_state_t
// - One sub-module, qeciphy_link_fail_mon: the consecutive-error counter, the threshold
//   compare and the sticky link_fail_o register.
//
// TESTING
// - FRAME_BYTES=9, payload "123456789" (0x31..0x39), CRC byte 0xF4 with tlast
//   -> 9 bytes on data_o, one frame_ok_o pulse, err_cnt_o=0.
// - FRAME_BYTES=1, payload 0x01, CRC byte 0x07 -> frame_ok_o.
//   Same payload with CRC byte 0x06 -> frame_err_o with frame_fmt_o=0, err_cnt_o=1.
// - FRAME_BYTES=8, tlast on payload byte 3 -> frame_err_o with frame_fmt_o=1.
//   The next correct 8+1 frame -> frame_ok_o.
// - CRC beat without tlast -> frame_err_o with frame_fmt_o=1; 5 following beats discarded.
//   A beat with tlast, then a correct frame -> frame_ok_o.
// - FAIL_THRESH=4: 3 bad, 1 good, 4 bad frames -> link_fail_o rises on the 8th frame's
//   status cycle; clear_i -> link_fail_o=0.
// - Assert rst_n_i mid-frame, then send a full correct frame -> frame_ok_o,
//   and no stale data_o appears.

Source files
------------

// File: rtl/qeciphy_crc_pkg.sv
// Shared CRC-8/SMBUS definitions for the QECIPHY byte-stream CRC paths.
//   CRC8_POLY / CRC8_INIT : polynomial 0x07, init 0x00 (MSB-first, no reflection,
//                           xorout 0x00)
//   crc8_step()           : one-byte CRC update, shared by the RX checker and the
//                           TX CRC insert path
//   rx_crc_state_t        : RX checker FSM states
package qeciphy_crc_pkg;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  typedef enum logic [1:0] {
    ST_PAYLOAD = 2'd0,
    ST_CHECK   = 2'd1,
    ST_SYNC    = 2'd2
  } rx_crc_state_t;

  // The incoming byte is xored into the register once, then shifted out MSB
  // first eight times.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/qeciphy_link_fail_mon.sv
// Consecutive bad-frame monitor.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   err_evt_i      : a bad frame is being reported on the next status cycle
//   ok_evt_i       : a good frame is being reported on the next status cycle
//   clear_i        : clears the consecutive count and link_fail_o
//   link_fail_o    : sticky, set once FAIL_THRESH consecutive bad frames are seen
// The events arrive one cycle ahead of the checker's registered status pulses,
// so link_fail_o rises in the same cycle as the frame_err_o that reaches the
// threshold.
module qeciphy_link_fail_mon #(
  parameter int FAIL_THRESH = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic err_evt_i,
  input  logic ok_evt_i,
  input  logic clear_i,
  output logic link_fail_o
);

  localparam int CW = $clog2(FAIL_THRESH + 1);

  logic [CW-1:0] consec_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      consec_cnt  <= '0;
      link_fail_o <= 1'b0;
    end else if (clear_i) begin
      // Clear beats a coincident error: that error is not counted.
      consec_cnt  <= '0;
      link_fail_o <= 1'b0;
    end else if (err_evt_i) begin
      if (consec_cnt < CW'(FAIL_THRESH)) begin
        consec_cnt <= consec_cnt + 1'b1;
      end
      if (consec_cnt >= CW'(FAIL_THRESH - 1)) begin
        link_fail_o <= 1'b1;
      end
    end else if (ok_evt_i) begin
      // A good frame breaks the run but leaves link_fail_o latched.
      consec_cnt <= '0;
    end
  end

endmodule

// File: rtl/qeciphy_rx_crc8_checker.sv
// Receive-side CRC-8/SMBUS checker.
// Frames are FRAME_BYTES payload bytes followed by one CRC byte marked with
// rx_last_i. Payload is forwarded one cycle later; the CRC byte never is.
//   clk_i, rst_n_i  : clock, asynchronous active-low reset
//   rx_data_i/rx_valid_i/rx_last_i : input byte stream, no backpressure
//   clear_i         : clears link_fail_o and the consecutive-error count
//   data_o/valid_o  : forwarded payload
//   frame_ok_o      : 1-cycle pulse, frame passed
//   frame_err_o     : 1-cycle pulse, frame failed; frame_fmt_o=1 framing error,
//                     0 CRC mismatch
//   link_fail_o     : sticky, FAIL_THRESH consecutive bad frames seen
//   err_cnt_o       : saturating bad-frame count, only built with
//                     QECIPHY_RX_CRC_ERR_CNT_EN defined (otherwise tied to 0)
//   state_dbg_o     : current FSM state (rx_crc_state_t encoding)
// Handshake: a beat is transferred on every cycle rx_valid_i=1; there is no
// ready. valid_o marks data_o for one cycle per forwarded byte.
module qeciphy_rx_crc8_checker
  import qeciphy_crc_pkg::*;
#(
  parameter int FRAME_BYTES = 8,
  parameter int FAIL_THRESH = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_valid_i,
  input  logic             rx_last_i,
  input  logic             clear_i,
  output logic [7:0]       data_o,
  output logic             valid_o,
  output logic             frame_ok_o,
  output logic             frame_err_o,
  output logic             frame_fmt_o,
  output logic             link_fail_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [1:0]       state_dbg_o
);

  rx_crc_state_t state;
  logic [7:0]    crc;
  logic [7:0]    byte_cnt;

  // Status events decided in the beat cycle; registered into the pulses below.
  logic ok_evt;
  logic err_evt;
  logic fmt_evt;

  always_comb begin
    ok_evt  = 1'b0;
    err_evt = 1'b0;
    fmt_evt = 1'b0;
    if (rx_valid_i) begin
      case (state)
        ST_PAYLOAD: begin
          if (rx_last_i) begin
            err_evt = 1'b1;
            fmt_evt = 1'b1;
          end
        end
        ST_CHECK: begin
          if (rx_last_i) begin
            if (rx_data_i == crc) ok_evt  = 1'b1;
            else                  err_evt = 1'b1;
          end else begin
            err_evt = 1'b1;
            fmt_evt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= ST_PAYLOAD;
      crc         <= CRC8_INIT;
      byte_cnt    <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_ok_o  <= 1'b0;
      frame_err_o <= 1'b0;
      frame_fmt_o <= 1'b0;
    end else begin
      valid_o     <= 1'b0;
      frame_ok_o  <= ok_evt;
      frame_err_o <= err_evt;
      frame_fmt_o <= fmt_evt;
      if (rx_valid_i) begin
        case (state)
          ST_PAYLOAD: begin
            if (rx_last_i) begin
              // Early tlast: drop the frame, keep looking for payload.
              crc      <= CRC8_INIT;
              byte_cnt <= '0;
            end else begin
              data_o   <= rx_data_i;
              valid_o  <= 1'b1;
              crc      <= crc8_step(crc, rx_data_i);
              byte_cnt <= byte_cnt + 8'd1;
              if (byte_cnt == 8'(FRAME_BYTES - 1)) begin
                state <= ST_CHECK;
              end
            end
          end
          ST_CHECK: begin
            if (rx_last_i) begin
              crc      <= CRC8_INIT;
              byte_cnt <= '0;
              state    <= ST_PAYLOAD;
            end else begin
              // Lost alignment: wait for the next tlast before trusting data.
              state <= ST_SYNC;
            end
          end
          ST_SYNC: begin
            if (rx_last_i) begin
              crc      <= CRC8_INIT;
              byte_cnt <= '0;
              state    <= ST_PAYLOAD;
            end
          end
          default: state <= ST_PAYLOAD;
        endcase
      end
    end
  end

  assign state_dbg_o = state;

  qeciphy_link_fail_mon #(
    .FAIL_THRESH (FAIL_THRESH)
  ) u_link_fail_mon (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .err_evt_i   (err_evt),
    .ok_evt_i    (ok_evt),
    .clear_i     (clear_i),
    .link_fail_o (link_fail_o)
  );

`ifdef QECIPHY_RX_CRC_ERR_CNT_EN
  // Lifetime bad-frame count; only reset clears it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_cnt_o <= '0;
    end else if (err_evt && (err_cnt_o != {CNT_W{1'b1}})) begin
      err_cnt_o <= err_cnt_o + CNT_W'(1);
    end
  end
`else
  assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_qeciphy_rx_crc8_checker.sv
module tb_qeciphy_rx_crc8_checker;

  localparam int FB    = 9;
  localparam int TH    = 4;
  localparam int CNT_W = 16;
  localparam int SW    = 4 + CNT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n_i = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]       rx_data_i = '0;
  logic             rx_valid_i = 1'b0;
  logic             rx_last_i = 1'b0;
  logic             clear_i = 1'b0;
  logic [7:0]       data_o;
  logic             valid_o;
  logic             frame_ok_o;
  logic             frame_err_o;
  logic             frame_fmt_o;
  logic             link_fail_o;
  logic [CNT_W-1:0] err_cnt_o;
  logic [1:0]       state_dbg_o;

  qeciphy_rx_crc8_checker #(
    .FRAME_BYTES (FB),
    .FAIL_THRESH (TH),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n_i),
    .rx_data_i   (rx_data_i),
    .rx_valid_i  (rx_valid_i),
    .rx_last_i   (rx_last_i),
    .clear_i     (clear_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .frame_ok_o  (frame_ok_o),
    .frame_err_o (frame_err_o),
    .frame_fmt_o (frame_fmt_o),
    .link_fail_o (link_fail_o),
    .err_cnt_o   (err_cnt_o),
    .state_dbg_o (state_dbg_o)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [7:0]    data_q[$];      // expected forwarded bytes
  logic [SW-1:0] stat_q[$];      // expected {ok, err, fmt, link_fail, err_cnt}
  logic [7:0]    frame_buf[$];   // payload bytes of the frame in progress
  int            mode = 0;       // 0 collecting, 1 expecting CRC, 2 resync
  int            m_consec = 0;
  logic          m_link = 1'b0;
  int unsigned   m_errcnt = 0;

  // Bit-serial CRC-8 (poly 0x07, init 0, MSB first) over a whole frame.
  function automatic logic [7:0] ref_crc(input logic [7:0] b[$]);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    foreach (b[i]) begin
      for (int k = 7; k >= 0; k--) begin
        fb = c[7] ^ b[i][k];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  task automatic report(input logic ok, input logic fmt);
    logic [CNT_W-1:0] ec;
    if (ok) begin
      m_consec = 0;
    end else begin
      if (m_consec < TH) m_consec++;
      if (m_consec == TH) m_link = 1'b1;
`ifdef QECIPHY_RX_CRC_ERR_CNT_EN
      if (m_errcnt < (2 ** CNT_W) - 1) m_errcnt++;
`endif
    end
    ec = CNT_W'(m_errcnt);
    stat_q.push_back({ok, ~ok, fmt, m_link, ec});
  endtask

  task automatic model_beat(input logic [7:0] d, input logic last);
    case (mode)
      0: begin
        if (last) begin
          report(1'b0, 1'b1);
          frame_buf.delete();
        end else begin
          data_q.push_back(d);
          frame_buf.push_back(d);
          if (frame_buf.size() == FB) mode = 1;
        end
      end
      1: begin
        if (last) begin
          report(d == ref_crc(frame_buf), 1'b0);
          frame_buf.delete();
          mode = 0;
        end else begin
          report(1'b0, 1'b1);
          mode = 2;
        end
      end
      default: begin
        if (last) begin
          frame_buf.delete();
          mode = 0;
        end
      end
    endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [7:0] d, input logic last, input bit gaps);
    model_beat(d, last);
    rx_data_i  = d;
    rx_last_i  = last;
    rx_valid_i = 1'b1;
    @(posedge clk); #1;
    rx_valid_i = 1'b0;
    rx_last_i  = 1'b0;
    rx_data_i  = 8'($urandom);
    if (gaps) repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // kind: 0 good, 1 bad CRC, 2 early tlast, 3 missing tlast
  task automatic send_frame(input int kind);
    logic [7:0] pl[$];
    int         n;
    for (int i = 0; i < FB; i++) pl.push_back(8'($urandom));
    case (kind)
      2: begin
        n = $urandom_range(1, FB);
        for (int i = 0; i < n - 1; i++) send_beat(pl[i], 1'b0, 1'b1);
        send_beat(pl[n-1], 1'b1, 1'b1);
      end
      3: begin
        foreach (pl[i]) send_beat(pl[i], 1'b0, 1'b1);
        send_beat(ref_crc(pl), 1'b0, 1'b1);
        repeat ($urandom_range(0, 5)) send_beat(8'($urandom), 1'b0, 1'b1);
        send_beat(8'($urandom), 1'b1, 1'b1);
      end
      default: begin
        foreach (pl[i]) send_beat(pl[i], 1'b0, 1'b1);
        send_beat(ref_crc(pl) ^ ((kind == 1) ? 8'($urandom_range(1, 255)) : 8'h00),
                  1'b1, 1'b1);
      end
    endcase
  endtask

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n_i) begin
      if (valid_o) begin
        checks++;
        if (data_q.size() == 0) begin
          errors++;
          $display("FAIL data_o: unexpected byte %02h, expected none", data_o);
        end else begin
          logic [7:0] e;
          e = data_q.pop_front();
          if (data_o !== e) begin
            errors++;
            $display("FAIL data_o: got %02h expected %02h", data_o, e);
          end
        end
      end
      if (frame_ok_o || frame_err_o) begin
        logic [SW-1:0] got;
        got = {frame_ok_o, frame_err_o, frame_fmt_o, link_fail_o, err_cnt_o};
        checks++;
        if (stat_q.size() == 0) begin
          errors++;
          $display("FAIL status: unexpected %0h, expected none", got);
        end else begin
          logic [SW-1:0] e;
          e = stat_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL status {ok,err,fmt,link,cnt}: got %0h expected %0h", got, e);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] vec[$];
    idle(2);
    check1("reset valid_o", valid_o, 0);
    check1("reset data_o", data_o, 0);
    check1("reset frame_ok_o", frame_ok_o, 0);
    check1("reset frame_err_o", frame_err_o, 0);
    check1("reset frame_fmt_o", frame_fmt_o, 0);
    check1("reset link_fail_o", link_fail_o, 0);
    check1("reset err_cnt_o", err_cnt_o, 0);
    rst_n_i = 1'b1;
    idle(2);

    // Standard check vector "123456789" -> 0xF4.
    for (int i = 0; i < 9; i++) send_beat(8'h31 + 8'(i), 1'b0, 1'b0);
    send_beat(8'hF4, 1'b1, 1'b0);
    idle(3);

    repeat (4) send_frame(0);
    send_frame(1);
    // tlast on payload byte 3, then a good frame.
    send_beat(8'hA1, 1'b0, 1'b0);
    send_beat(8'hA2, 1'b0, 1'b0);
    send_beat(8'hA3, 1'b1, 1'b0);
    send_frame(0);
    // CRC beat without tlast, 5 discarded beats, tlast beat, good frame.
    for (int i = 0; i < FB; i++) vec.push_back(8'($urandom));
    foreach (vec[i]) send_beat(vec[i], 1'b0, 1'b0);
    send_beat(ref_crc(vec), 1'b0, 1'b0);
    repeat (5) send_beat(8'($urandom), 1'b0, 1'b0);
    send_beat(8'h00, 1'b1, 1'b0);
    send_frame(0);
    idle(3);

    // Threshold: clear, 3 bad, 1 good, 4 bad -> link_fail on 8th status.
    clear_i = 1'b1; m_consec = 0; m_link = 1'b0;
    idle(1);
    clear_i = 1'b0;
    idle(1);
    check1("link_fail after clear", link_fail_o, 0);
    repeat (3) send_frame(1);
    idle(2);
    check1("link_fail after 3 bad", link_fail_o, 0);
    send_frame(0);
    repeat (3) send_frame($urandom_range(1, 2));
    idle(2);
    check1("link_fail after 3 bad again", link_fail_o, 0);
    send_frame(1);
    idle(2);
    check1("link_fail after 4 bad", link_fail_o, 1);
    send_frame(0);
    idle(2);
    check1("link_fail sticky over good", link_fail_o, 1);
    clear_i = 1'b1; m_consec = 0; m_link = 1'b0;
    idle(1);
    clear_i = 1'b0;
    idle(1);
    check1("link_fail cleared", link_fail_o, 0);

    // Reset mid-frame: partial frame dropped, next frame good.
    for (int i = 0; i < 4; i++) send_beat(8'($urandom), 1'b0, 1'b0);
    idle(2);
    rst_n_i = 1'b0;
    frame_buf.delete(); mode = 0; m_consec = 0; m_link = 1'b0; m_errcnt = 0;
    idle(1);
    check1("reset mid-frame valid_o", valid_o, 0);
    check1("reset mid-frame err_cnt_o", err_cnt_o, 0);
    rst_n_i = 1'b1;
    idle(1);
    send_frame(0);
    idle(3);

    // Randomised mix.
    for (int f = 0; f < 40; f++) begin
      int r;
      r = $urandom_range(0, 9);
      send_frame((r < 5) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3);
      if ($urandom_range(0, 7) == 0) begin
        clear_i = 1'b1; m_consec = 0; m_link = 1'b0;
        idle(1);
        clear_i = 1'b0;
      end
    end
    idle(5);
    check1("link_fail final", link_fail_o, m_link);
    check1("data queue drained", data_q.size(), 0);
    check1("status queue drained", stat_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
